// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encoding and default timing constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 10;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int unsigned width_for(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, lock qualification, timeout retries and fault for one PLL.
//   state     | meaning
//   RESET_PLL | pll_rst pulse in progress
//   WAIT_LOCK | PLL released, waiting for lock or timeout
//   STABLE    | lock seen, qualifying it for LOCK_STABLE_CYCLES
//   RUN       | lock qualified, ready asserted
//   FAULT     | retries exhausted, PLL held in reset until relock_req
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter  int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter  int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter  int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter  int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  localparam int unsigned RETRY_W             = width_for(MAX_RETRIES + 1)
) (
  input  logic               refclk,
  input  logic               rst_n,
  output logic               pll_rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state
);

  localparam int unsigned CNT_MAX =
    (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES)
      ? ((RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES)
      : ((LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ? LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES);
  localparam int unsigned CNT_W = width_for(CNT_MAX);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, ready_q, fault_q;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (relock_req) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = RESET_PLL;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Lock loss is checked first so a drop on the final count still restarts.
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = RESET_PLL;
            cnt_d   = '0;
          end
        end
        FAULT: begin
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge as state_q.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == RESET_PLL) || (state_d == FAULT);
      ready_q   <= (state_d == RUN);
      fault_q   <= (state_d == FAULT);
    end
  end

  assign pll_rst     = pll_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed and randomized bring-up scenarios for pll_lock_sequencer with an edge-count reference model.
module tb_pll_lock_sequencer;

  localparam int RST = 4;
  localparam int LS  = 8;
  localparam int TO  = 32;
  localparam int MR  = 2;
  localparam int BIG = 1 << 30;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_rst;
  logic       pll_locked;
  logic       relock_req;
  logic       ready;
  logic       fault;
  logic [1:0] retry_count;
  logic [2:0] state;

  int n_assert = 0;
  int n_fail   = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RST),
    .LOCK_STABLE_CYCLES  (LS),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MR)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_rst     (pll_rst),
    .pll_locked  (pll_locked),
    .relock_req  (relock_req),
    .ready       (ready),
    .fault       (fault),
    .retry_count (retry_count),
    .state       (state)
  );

  always #10 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Edge (relative to the edge that entered or released RESET_PLL) on which ready rises,
  // given the first edge e0 that samples pll_locked high.  WAIT_LOCK first evaluates at RST+1.
  function automatic int exp_ready(input int e0);
    int s;
    s = (e0 + 2 > RST + 1) ? e0 + 2 : RST + 1;
    return s + LS;
  endfunction

  // Drives pll_locked per a piecewise waveform, sampling once per falling edge (k=0 is now).
  task automatic run_seq(input int on_at, input int off_at, input int on2_at, input int probe_k,
                         input int max_k, output int rst_hi, output int rise, output int fall,
                         output logic [2:0] probe_st);
    logic prev_rdy;
    rst_hi   = 0;
    rise     = -1;
    fall     = -1;
    probe_st = 3'b111;
    prev_rdy = ready;
    for (int k = 0; k <= max_k; k++) begin
      pll_locked = (k >= on_at) && !(k >= off_at && k < on2_at);
      if (pll_rst) rst_hi++;
      if (k == probe_k) probe_st = state;
      if (k > 0 && !ready && prev_rdy && fall < 0) fall = k;
      if (k > 0 && ready && !prev_rdy) begin
        rise = k;
        break;
      end
      prev_rdy = ready;
      @(negedge refclk);
    end
  endtask

  task automatic run_timeout(output int rise1, output int rise2, output int fault_at,
                             output int hi_before, output logic [1:0] retry_a,
                             output logic [1:0] retry_b, output logic [1:0] retry_end,
                             output logic rst_end, output logic fault_end);
    logic prev_rst;
    rise1 = -1; rise2 = -1; fault_at = -1; hi_before = 0;
    retry_a = 2'b11; retry_b = 2'b11; retry_end = 2'b11; rst_end = 1'b0; fault_end = 1'b0;
    prev_rst = pll_rst;
    for (int k = 0; k <= 127; k++) begin
      pll_locked = 1'b0;
      if (k > 0 && pll_rst && !prev_rst) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      if (fault && fault_at < 0) fault_at = k;
      if (pll_rst && fault_at < 0) hi_before++;
      if (k == 2 * RST + TO) retry_a = retry_count;
      if (k == 2 * (RST + TO) + RST) retry_b = retry_count;
      if (k == 127) begin
        retry_end = retry_count;
        rst_end   = pll_rst;
        fault_end = fault;
      end
      prev_rst = pll_rst;
      if (k < 127) @(negedge refclk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, rise, fall, s_edge, off_at, a, h;
    int r1, r2, f_at, hb;
    logic [2:0] pst;
    logic [1:0] ra, rb, re;
    logic rend, fend;

    rst_n = 1'b0; pll_locked = 1'b0; relock_req = 1'b0;
    repeat (3) @(negedge refclk);
    chk("reset_state", state, 0);
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_ready", ready, 0);
    chk("reset_fault", fault, 0);
    chk("reset_retry", retry_count, 0);

    // Normal bring-up: lock raised 10 cycles after release
    rst_n = 1'b1;
    run_seq(10, BIG, BIG, -1, 60, hi, rise, fall, pst);
    chk("bringup_rst_pulse", hi, RST);
    chk("bringup_ready_edge", rise, exp_ready(11));
    chk("bringup_retry", retry_count, 0);
    chk("bringup_state", state, 3);

    // Glitch at STABLE count 5
    pll_locked = 1'b0; relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    s_edge = exp_ready(11) - LS;
    off_at = s_edge + 5;
    run_seq(10, off_at, off_at + 3, off_at + 3, 80, hi, rise, fall, pst);
    chk("glitch_rst_pulse", hi, RST);
    chk("glitch_back_to_wait", pst, 1);
    chk("glitch_ready_edge", rise, exp_ready(off_at + 4));

    // Timeout retries then FAULT
    pll_locked = 1'b0; relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    run_timeout(r1, r2, f_at, hb, ra, rb, re, rend, fend);
    chk("timeout_rise1", r1, RST + TO);
    chk("timeout_rise2", r2, 2 * (RST + TO));
    chk("timeout_fault_edge", f_at, 3 * (RST + TO));
    chk("timeout_rst_width", hb, 3 * RST);
    chk("timeout_retry1", ra, 1);
    chk("timeout_retry2", rb, 2);
    chk("fault_retry_hold", re, MR);
    chk("fault_pll_rst", rend, 1);
    chk("fault_flag", fend, 1);

    // Recovery from FAULT
    pll_locked = 1'b1; relock_req = 1'b1;
    @(negedge refclk);
    relock_req = 1'b0;
    chk("recover_fault_clr", fault, 0);
    chk("recover_retry_clr", retry_count, 0);
    run_seq(0, BIG, BIG, -1, 60, hi, rise, fall, pst);
    chk("recover_rst_pulse", hi, RST);
    chk("recover_ready_edge", rise, exp_ready(0));

    // Lock loss in RUN, random relock time
    a = $urandom_range(7, 20);
    run_seq(a, BIG, BIG, -1, 80, hi, rise, fall, pst);
    chk("lockloss_ready_fall", fall, 3);
    chk("lockloss_rst_pulse", hi, RST);
    chk("lockloss_ready_edge", rise, 3 + exp_ready(a + 1 - 3));
    chk("lockloss_retry", retry_count, 0);

    // Short async reset in RUN
    @(negedge refclk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_pll_rst", pll_rst, 1);
    chk("midrst_ready", ready, 0);
    chk("midrst_state", state, 0);
    rst_n = 1'b1;
    run_seq(0, BIG, BIG, -1, 60, hi, rise, fall, pst);
    chk("midrst_rst_pulse", hi, RST);
    chk("midrst_ready_edge", rise, exp_ready(1));

    // Randomized relock hold length and lock arrival
    for (int r = 0; r < 4; r++) begin
      h = $urandom_range(1, 4);
      a = $urandom_range(0, 25);
      pll_locked = 1'b0; relock_req = 1'b1;
      repeat (h) @(negedge refclk);
      chk("relock_hold_state", state, 0);
      chk("relock_hold_pll_rst", pll_rst, 1);
      relock_req = 1'b0;
      run_seq(a, BIG, BIG, -1, 80, hi, rise, fall, pst);
      chk("rand_rst_pulse", hi, RST);
      chk("rand_ready_edge", rise, exp_ready(a + 1));
      chk("rand_retry", retry_count, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
